// File: rtl/vx_ti_node_gather.sv
// Purpose: gathers out-of-order per-word TI fetch responses into BVH node records, released in allocation order.
// Latency: the last word written at edge t raises out_valid in cycle t+1; there is no rsp->out bypass.
// Backpressure: out_ready=0 holds the head record stable; alloc_ready drops when all slots are occupied; rsp_ready is 1 outside reset.
// Optional: define VX_TI_GATHER_ERR_EN to add the sticky err output (response to a free slot, or a duplicate word).
module vx_ti_node_gather #(
  parameter int NUM_SLOTS  = 8,
  parameter int NUM_WORDS  = 8,
  parameter int WORD_WIDTH = 32,
  parameter int META_WIDTH = 16,
  localparam int TAG_W     = $clog2(NUM_SLOTS),
  localparam int IDX_W     = $clog2(NUM_WORDS),
  localparam int CNT_W     = TAG_W + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alloc_valid,
  input  logic [META_WIDTH-1:0]           alloc_meta,
  output logic                            alloc_ready,
  output logic [TAG_W-1:0]                alloc_tag,
  input  logic                            rsp_valid,
  input  logic [TAG_W-1:0]                rsp_tag,
  input  logic [IDX_W-1:0]                rsp_word_idx,
  input  logic [WORD_WIDTH-1:0]           rsp_data,
  output logic                            rsp_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [META_WIDTH-1:0]           out_meta,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] out_data
`ifdef VX_TI_GATHER_ERR_EN
  ,
  output logic                            err
`endif
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SLOTS);

  logic [1:0]            state_q [NUM_SLOTS];
  logic [NUM_WORDS-1:0]  mask_q  [NUM_SLOTS];
  logic [META_WIDTH-1:0] meta_q  [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] data_q  [NUM_SLOTS][NUM_WORDS];
  logic [TAG_W-1:0]      head_q;
  logic [TAG_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  alloc_fire;
  logic                  out_fire;
  logic                  rsp_live;
  logic                  rsp_hit;
  logic [NUM_WORDS-1:0]  rsp_bit;
  logic [NUM_WORDS-1:0]  mask_upd;

  // Handshakes are forced low while reset is held so nothing is granted or accepted.
  assign alloc_ready = ~reset & (count_q < CNT_MAX);
  assign alloc_tag   = tail_q;
  assign rsp_ready   = ~reset;
  assign out_valid   = ~reset & (state_q[head_q] == ST_FULL);
  assign out_meta    = meta_q[head_q];
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign out_fire    = out_valid & out_ready;

  // A response only lands in an occupied slot that is neither being released nor
  // re-claimed on this edge; anything else is treated as hitting a free slot.
  assign rsp_live = rsp_valid & ~reset;
  assign rsp_hit  = rsp_live
                  & (state_q[rsp_tag] != ST_FREE)
                  & ~(out_fire & (rsp_tag == head_q))
                  & ~(alloc_fire & (rsp_tag == tail_q));
  assign rsp_bit  = NUM_WORDS'(1) << rsp_word_idx;
  assign mask_upd = mask_q[rsp_tag] | rsp_bit;

  // Flatten the head record onto the output bus, word i in slice i.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_data[i*WORD_WIDTH +: WORD_WIDTH] = data_q[head_q][i];
    end
  end

  // Slot lifecycle, ring pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= ST_FREE;
        mask_q[s]  <= '0;
      end
    end else begin
      if (alloc_fire) begin
        state_q[tail_q] <= ST_PEND;
        mask_q[tail_q]  <= '0;
        tail_q          <= tail_q + TAG_W'(1);
      end
      if (out_fire) begin
        state_q[head_q] <= ST_FREE;
        head_q          <= head_q + TAG_W'(1);
      end
      if (rsp_hit) begin
        mask_q[rsp_tag] <= mask_upd;
        if (&mask_upd) begin
          state_q[rsp_tag] <= ST_FULL;
        end
      end
      case ({alloc_fire, out_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Metadata captured at allocation; no reset needed as it is only read once the slot is full.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      meta_q[tail_q] <= alloc_meta;
    end
  end

  // Word payload; a duplicate word simply overwrites the earlier value.
  always_ff @(posedge clk) begin
    if (rsp_hit) begin
      data_q[rsp_tag][rsp_word_idx] <= rsp_data;
    end
  end

`ifdef VX_TI_GATHER_ERR_EN
  logic rsp_dup;
  assign rsp_dup = rsp_hit & mask_q[rsp_tag][rsp_word_idx];

  // Sticky protocol error: dropped response or repeated word, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((rsp_live & ~rsp_hit) | rsp_dup) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_ti_node_gather.sv
// Directed bench for vx_ti_node_gather: alloc order and metadata are queued on allocation,
// word data is tracked per slot, and every released record is popped and compared.
// Covers reset, in-order and out-of-order fills, head-of-line, full/wrap, backpressure, duplicates and errors.
module tb_vx_ti_node_gather;

  localparam int DW = 256;

  typedef struct packed {
    logic [2:0]  tag;
    logic [15:0] meta;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid;
  logic [15:0]   alloc_meta;
  logic          alloc_ready;
  logic [2:0]    alloc_tag;
  logic          rsp_valid;
  logic [2:0]    rsp_tag;
  logic [2:0]    rsp_word_idx;
  logic [31:0]   rsp_data;
  logic          rsp_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_meta;
  logic [DW-1:0] out_data;
`ifdef VX_TI_GATHER_ERR_EN
  logic          err;
`endif

  vx_ti_node_gather dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_meta   (alloc_meta),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .rsp_valid    (rsp_valid),
    .rsp_tag      (rsp_tag),
    .rsp_word_idx (rsp_word_idx),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_meta     (out_meta),
`ifdef VX_TI_GATHER_ERR_EN
    .out_data     (out_data),
    .err          (err)
`else
    .out_data     (out_data)
`endif
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            rel_cnt = 0;
  exp_t          sb [$];
  logic [DW-1:0] mdata [8];
  logic [7:0]    malloc;
  logic [2:0]    mhead;
  logic [2:0]    mtail;
  int            mcount;

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    malloc = '0;
    mhead  = '0;
    mtail  = '0;
    mcount = 0;
  endtask

  // Advance one clock; a release happening on this edge is popped from the scoreboard.
  task automatic step();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_release: observed meta %0h expected no release", out_meta);
      end else begin
        e = sb.pop_front();
        check("rel_meta", out_meta, e.meta);
        check("rel_data", out_data, mdata[e.tag]);
        malloc[e.tag] = 1'b0;
        mhead  = mhead + 3'd1;
        mcount = mcount - 1;
        rel_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    alloc_valid = 1'b0;
    rsp_valid   = 1'b0;
    step();
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_alloc_ready", alloc_ready, 0);
    check("rst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    #1;
    model_clear();
  endtask

  task automatic do_alloc(input logic [15:0] m);
    int n = 0;
    while (alloc_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("alloc_wait", alloc_ready, 1);
    check("alloc_tag", alloc_tag, mtail);
    if (alloc_ready === 1'b1) begin
      alloc_valid = 1'b1;
      alloc_meta  = m;
      step();
      alloc_valid = 1'b0;
      sb.push_back('{tag: mtail, meta: m});
      malloc[mtail] = 1'b1;
      mtail  = mtail + 3'd1;
      mcount = mcount + 1;
    end
  endtask

  task automatic send(input logic [2:0] tag, input logic [2:0] idx, input logic [31:0] d);
    rsp_valid    = 1'b1;
    rsp_tag      = tag;
    rsp_word_idx = idx;
    rsp_data     = d;
    step();
    rsp_valid = 1'b0;
    if (malloc[tag]) mdata[tag][int'(idx)*32 +: 32] = d;
  endtask

  task automatic fill(input logic [2:0] tag, input logic [31:0] base);
    for (int i = 0; i < 8; i++) send(tag, 3'(i), base + 32'(i));
  endtask

  initial begin
    int ord [8];
    int rc;
    ord = '{7, 3, 0, 1, 2, 4, 5, 6};
    reset = 1'b1; alloc_valid = 1'b0; alloc_meta = '0; rsp_valid = 1'b0;
    rsp_tag = '0; rsp_word_idx = '0; rsp_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mdata[i] = '0;
    model_clear();

    // Reset state
    do_reset();
    check("post_rst_alloc_ready", alloc_ready, 1);
    check("post_rst_rsp_ready", rsp_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
`ifdef VX_TI_GATHER_ERR_EN
    check("post_rst_err", err, 0);
`endif

    // Basic in-order fill, one-cycle latency after word 7
    do_alloc(16'h0042);
    for (int i = 0; i < 7; i++) send(3'd0, 3'(i), 32'hA0 + 32'(i));
    check("basic_not_yet", out_valid, 0);
    send(3'd0, 3'd7, 32'hA7);
    check("basic_lat1", out_valid, 1);
    check("basic_w3", out_data[3*32 +: 32], 32'hA3);
    check("basic_meta", out_meta, 16'h0042);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("basic_drained", out_valid, 0);
    check("basic_rel_cnt", rel_cnt, 1);

    // Out-of-order words and head-of-line blocking
    do_reset();
    out_ready = 1'b1;
    do_alloc(16'h0100);
    do_alloc(16'h0101);
    rc = rel_cnt;
    for (int i = 0; i < 8; i++) send(3'd1, 3'(ord[i]), 32'hB0 + 32'(ord[i]));
    check("hol_blocked0", out_valid, 0);
    step();
    check("hol_blocked1", out_valid, 0);
    check("hol_no_rel", rel_cnt, rc);
    fill(3'd0, 32'hC0);
    check("ooo_head_ready", out_valid, 1);
    check("ooo_head_meta", out_meta, 16'h0100);
    step();
    check("ooo_second_ready", out_valid, 1);
    check("ooo_second_meta", out_meta, 16'h0101);
    step();
    check("ooo_drained", out_valid, 0);
    check("ooo_rel_cnt", rel_cnt, rc + 2);
    out_ready = 1'b0;

    // Full and wrap-around
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(16'h0200 + 16'(i));
    alloc_valid = 1'b1;
    alloc_meta  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_alloc_ready", alloc_ready, 0);
    end
    alloc_valid = 1'b0;
    fill(mhead, 32'hD0);
    check("full_still_full", alloc_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("full_ready_after_rel", alloc_ready, 1);
    do_alloc(16'h0300);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fill(mhead, 32'h1000 * 32'(k + 1));
      check("wrap_full", alloc_ready, 0);
      step();
      check("wrap_freed", alloc_ready, 1);
      do_alloc(16'h0400 + 16'(k));
    end
    for (int k = 0; k < 8; k++) begin
      fill(mhead, 32'h5000 + 32'h100 * 32'(k));
      step();
    end
    check("wrap_sb_empty", sb.size(), 0);
    check("wrap_drained", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure holds the head record stable
    do_reset();
    do_alloc(16'h0500);
    do_alloc(16'h0501);
    fill(3'd0, 32'hE0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, mdata[0]);
      check("bp_meta", out_meta, 16'h0500);
      step();
    end
    rc = rel_cnt;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_one_release", rel_cnt, rc + 1);
    check("bp_after", out_valid, 0);

    // Dropped response to a free slot, duplicate words, reset clearing state
    do_reset();
    send(3'd3, 3'd0, 32'h55);
`ifdef VX_TI_GATHER_ERR_EN
    check("err_free_slot", err, 1);
`endif
    check("drop_no_out", out_valid, 0);
    do_reset();
`ifdef VX_TI_GATHER_ERR_EN
    check("err_cleared", err, 0);
`endif
    do_alloc(16'h0600);
    send(3'd0, 3'd2, 32'h11);
    send(3'd0, 3'd2, 32'h22);
`ifdef VX_TI_GATHER_ERR_EN
    check("err_dup", err, 1);
`endif
    for (int i = 0; i < 8; i++) if (i != 2) send(3'd0, 3'(i), 32'hF0 + 32'(i));
    check("dup_full", out_valid, 1);
    check("dup_second_value", out_data[2*32 +: 32], 32'h22);
    do_reset();
    check("rst_discards_full", out_valid, 0);
    check("rst_tail_zero", alloc_tag, 0);
`ifdef VX_TI_GATHER_ERR_EN
    check("err_cleared2", err, 0);
`endif
    do_alloc(16'h0700);
    for (int i = 0; i < 7; i++) send(3'd0, 3'(i), 32'h70 + 32'(i));
    check("rst_slot_partial", out_valid, 0);
    send(3'd0, 3'd7, 32'h77);
    out_ready = 1'b1;
    check("rst_slot_complete", out_valid, 1);
    step();
    out_ready = 1'b0;
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
